// File: rtl/wavetable_voice_scheduler_if.sv
// rtl/wavetable_voice_scheduler_if.sv - control, wavetable and sample-output bundle for the voice scheduler
interface wavetable_voice_scheduler_if #(
    parameter int VOICES = 4
);
    localparam int VW = $clog2(VOICES);

    logic          sample_tick;
    logic          wr_en;
    logic [VW-1:0] wr_voice;
    logic [31:0]   wr_incr;
    logic          wr_enable;
    logic          wr_reset_phase;
    logic          overrun_clr;
    logic [7:0]    wt_phase;
    logic [31:0]   wt_q;
    logic [31:0]   sample_out;
    logic          sample_valid;
    logic          busy;
    logic          overrun;

    // master: host plus wavetable side; slave: the scheduler itself
    modport master (
        output sample_tick, wr_en, wr_voice, wr_incr, wr_enable, wr_reset_phase,
               overrun_clr, wt_q,
        input  wt_phase, sample_out, sample_valid, busy, overrun
    );

    modport slave (
        input  sample_tick, wr_en, wr_voice, wr_incr, wr_enable, wr_reset_phase,
               overrun_clr, wt_q,
        output wt_phase, sample_out, sample_valid, busy, overrun
    );
endinterface

// File: rtl/wavetable_voice_scheduler.sv
// rtl/wavetable_voice_scheduler.sv - time-multiplexes one wavetable port across VOICES oscillators and mixes them
module wavetable_voice_scheduler #(
    parameter int VOICES     = 4,
    parameter int WT_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    wavetable_voice_scheduler_if.slave   bus
);
    localparam int VW = $clog2(VOICES);
    localparam int SW = 32 + VW;
    localparam logic [1:0] LAT_LAST = 2'((WT_LATENCY > 0) ? WT_LATENCY - 1 : 0);

    typedef enum logic [1:0] {IDLE, LOOKUP, CAPTURE, DONE} state_t;

    state_t             state, next_state;
    logic [VW-1:0]      v;
    logic [1:0]         lat_cnt;
    logic signed [SW-1:0] sum, sum_next, contrib;
    logic [31:0]        acc  [VOICES];
    logic [31:0]        incr [VOICES];
    logic [VOICES-1:0]  en;
    logic [31:0]        sample_q;
    logic               valid_q, overrun_q, last_voice;

    assign last_voice    = (v == VW'(VOICES - 1));
    assign contrib       = en[v] ? {{VW{bus.wt_q[31]}}, bus.wt_q} : '0;
    assign sum_next      = sum + contrib;

    assign bus.wt_phase     = acc[v][31:24];
    assign bus.busy         = (state != IDLE);
    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.overrun      = overrun_q;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.sample_tick) next_state = (WT_LATENCY == 0) ? CAPTURE : LOOKUP;
            LOOKUP:  if (lat_cnt == LAT_LAST) next_state = CAPTURE;
            CAPTURE: begin
                if (last_voice) next_state = DONE;
                else            next_state = (WT_LATENCY == 0) ? CAPTURE : LOOKUP;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            v         <= '0;
            lat_cnt   <= '0;
            sum       <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state   <= next_state;
            valid_q <= 1'b0;
            lat_cnt <= (state == LOOKUP && next_state == LOOKUP) ? lat_cnt + 2'd1 : 2'd0;
            if (state == IDLE && bus.sample_tick) begin
                sum <= '0;
                v   <= '0;
            end
            // Final sum is registered on the last capture so it is presented alongside the DONE pulse
            if (state == CAPTURE) begin
                sum <= sum_next;
                v   <= v + 1'b1;
                if (last_voice) begin
                    sample_q <= 32'(sum_next >>> VW);
                    valid_q  <= 1'b1;
                end
            end
            if (bus.sample_tick && state != IDLE) overrun_q <= 1'b1;
            else if (bus.overrun_clr)             overrun_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < VOICES; i++) begin
                acc[i]  <= '0;
                incr[i] <= '0;
            end
            en <= '0;
        end else begin
            for (int i = 0; i < VOICES; i++) begin
                if (bus.wr_en && bus.wr_voice == VW'(i)) begin
                    incr[i] <= bus.wr_incr;
                    en[i]   <= bus.wr_enable;
                end
                // A phase reset beats a same-cycle advance of that voice
                if (bus.wr_en && bus.wr_reset_phase && bus.wr_voice == VW'(i))
                    acc[i] <= '0;
                else if (state == CAPTURE && v == VW'(i) && en[i])
                    acc[i] <= acc[i] + incr[i];
            end
        end
    end
endmodule

// File: tb/tb_wavetable_voice_scheduler.sv
// tb/tb_wavetable_voice_scheduler.sv - scoreboard bench for wavetable_voice_scheduler with a registered table stub
module tb_wavetable_voice_scheduler;
    localparam int V  = 4;
    localparam int L  = 1;
    localparam int VW = 2;
    localparam int FRAME = V * (L + 1) + 1;

    logic clk = 0;
    logic reset_n = 0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    wavetable_voice_scheduler_if #(.VOICES(V)) bus ();

    wavetable_voice_scheduler #(.VOICES(V), .WT_LATENCY(L)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] tbl [256];
    always @(posedge clk) bus.wt_q <= tbl[bus.wt_phase];

    typedef struct { logic [31:0] val; int cyc; } exp_t;
    exp_t exp_q[$];

    logic [31:0] m_acc [V];
    logic [31:0] m_incr[V];
    bit          m_en  [V];
    logic [7:0]  m_ph  [V];
    logic [7:0]  obs_ph[V];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && bus.sample_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 64'(bus.sample_out), 64'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sample_out", 64'(bus.sample_out), 64'(e.val));
                chk("valid_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic fill_tbl(input bit rnd, input logic [31:0] c);
        for (int i = 0; i < 256; i++) tbl[i] = rnd ? $urandom : c;
    endtask

    task automatic model_reset();
        for (int i = 0; i < V; i++) begin
            m_acc[i] = 0; m_incr[i] = 0; m_en[i] = 0;
        end
    endtask

    task automatic model_write(input int wv, input logic [31:0] wi, input bit we, input bit wr);
        m_incr[wv] = wi;
        m_en[wv]   = we;
        if (wr) m_acc[wv] = 0;
    endtask

    task automatic do_write(input int wv, input logic [31:0] wi, input bit we, input bit wr);
        bus.wr_en = 1; bus.wr_voice = wv[VW-1:0]; bus.wr_incr = wi;
        bus.wr_enable = we; bus.wr_reset_phase = wr;
        @(negedge clk);
        bus.wr_en = 0; bus.wr_reset_phase = 0;
        model_write(wv, wi, we, wr);
    endtask

    // Starts at a negedge with the DUT idle; ends at the first idle negedge after the frame.
    task automatic run_frame(input bit use_c = 0, input logic [31:0] c = 0,
                             input bit do_wr = 0, input int wv = 0, input logic [31:0] wi = 0,
                             input bit we = 0, input bit wrp = 0,
                             input int xk = 0, input bit xclr = 0);
        longint s = 0;
        int wk;
        exp_t e;
        for (int i = 0; i < V; i++) begin
            m_ph[i] = m_acc[i][31:24];
            if (m_en[i]) begin
                s += longint'($signed(tbl[m_ph[i]]));
                m_acc[i] += m_incr[i];
            end
        end
        e.val = use_c ? c : 32'(s >>> VW);
        e.cyc = cyc + FRAME;
        exp_q.push_back(e);
        wk = (wv + 1) * (L + 1);
        bus.sample_tick = 1;
        for (int k = 1; k <= FRAME + 1; k++) begin
            @(negedge clk);
            bus.sample_tick = 0; bus.wr_en = 0; bus.wr_reset_phase = 0; bus.overrun_clr = 0;
            if (k <= V * (L + 1)) begin
                int vi;
                vi = (k - 1) / (L + 1);
                chk("wt_phase", 64'(bus.wt_phase), 64'(m_ph[vi]));
                if ((k - 1) % (L + 1) == 0) obs_ph[vi] = bus.wt_phase;
            end
            chk("busy", 64'(bus.busy), (k <= FRAME) ? 64'd1 : 64'd0);
            if (do_wr && k == wk) begin
                bus.wr_en = 1; bus.wr_voice = wv[VW-1:0]; bus.wr_incr = wi;
                bus.wr_enable = we; bus.wr_reset_phase = wrp;
            end
            if (k == xk) begin
                bus.sample_tick = 1; bus.overrun_clr = xclr;
            end
        end
        if (do_wr) model_write(wv, wi, we, wrp);
    endtask

    initial begin
        bus.sample_tick = 0; bus.wr_en = 0; bus.wr_voice = 0; bus.wr_incr = 0;
        bus.wr_enable = 0; bus.wr_reset_phase = 0; bus.overrun_clr = 0;
        fill_tbl(0, 32'h0);
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_wt_phase", 64'(bus.wt_phase), 0);
        chk("rst_sample_out", 64'(bus.sample_out), 0);
        chk("rst_valid", 64'(bus.sample_valid), 0);
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_overrun", 64'(bus.overrun), 0);
        reset_n = 1;
        @(negedge clk);

        // Latency and scaling
        fill_tbl(0, 32'h4000_0000);
        do_write(0, 32'h0100_0000, 1, 0);
        run_frame(1, 32'h1000_0000);
        for (int i = 1; i < V; i++) do_write(i, 32'h0, 1, 0);
        run_frame(1, 32'h4000_0000);

        // Signed mixing
        fill_tbl(0, 32'h8000_0000);
        run_frame(1, 32'h8000_0000);
        fill_tbl(0, 32'hFFFF_FFFF);
        tbl[8'h40] = 32'h0000_0004;
        do_write(0, 32'h0, 0, 1);
        do_write(1, 32'h0, 0, 1);
        do_write(2, 32'h4000_0000, 1, 1);
        do_write(3, 32'h4000_0000, 1, 1);
        run_frame();
        do_write(0, 32'h0, 1, 0);
        do_write(1, 32'h0, 1, 0);
        do_write(2, 32'h0, 1, 0);
        do_write(3, 32'h0, 1, 0);
        run_frame(1, 32'h0000_0001);

        // Phase advance and wrap; voice 1 disabled with a nonzero increment
        fill_tbl(1, 0);
        do_write(0, 32'h8000_0000, 1, 1);
        do_write(1, 32'h1234_5678, 0, 1);
        do_write(2, 32'h0, 0, 1);
        do_write(3, 32'h0, 0, 1);
        run_frame(); chk("ph_wrap_f0", 64'(obs_ph[0]), 64'h00);
        run_frame(); chk("ph_wrap_f1", 64'(obs_ph[0]), 64'h80);
        run_frame(); chk("ph_wrap_f2", 64'(obs_ph[0]), 64'h00);
        chk("ph_disabled", 64'(obs_ph[1]), 64'h00);
        do_write(0, 32'h0100_0000, 1, 1);
        run_frame(); chk("ph_step_f0", 64'(obs_ph[0]), 64'h00);
        run_frame(); chk("ph_step_f1", 64'(obs_ph[0]), 64'h01);
        run_frame(); chk("ph_step_f2", 64'(obs_ph[0]), 64'h02);

        // Write collision on voice 2 during its capture
        for (int i = 0; i < V; i++) do_write(i, $urandom | 32'h0100_0000, 1, 0);
        run_frame();
        run_frame(0, 0, 1, 2, $urandom, 1, 1);
        run_frame();
        chk("coll_ph2", 64'(obs_ph[2]), 64'h00);

        // Overrun
        run_frame(0, 0, 0, 0, 0, 0, 0, 4, 0);
        chk("overrun_set", 64'(bus.overrun), 1);
        repeat (2) @(negedge clk);
        chk("overrun_sticky", 64'(bus.overrun), 1);
        bus.overrun_clr = 1;
        @(negedge clk);
        bus.overrun_clr = 0;
        chk("overrun_clr", 64'(bus.overrun), 0);
        run_frame(0, 0, 0, 0, 0, 0, 0, 3, 1);
        chk("overrun_set_wins", 64'(bus.overrun), 1);

        // Randomised frames, config writes and in-frame collisions
        for (int n = 0; n < 24; n++) begin
            int nw;
            fill_tbl(1, 0);
            nw = $urandom_range(0, 2);
            for (int j = 0; j < nw; j++)
                do_write($urandom_range(0, V - 1), $urandom, 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0)
                run_frame(0, 0, 1, $urandom_range(0, V - 1), $urandom, 1'($urandom), 1'($urandom));
            else
                run_frame();
        end

        // Reset mid-frame
        bus.sample_tick = 1;
        @(negedge clk);
        bus.sample_tick = 0;
        repeat (3) @(negedge clk);
        reset_n = 0;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_wt_phase", 64'(bus.wt_phase), 0);
        chk("mid_rst_sample_out", 64'(bus.sample_out), 0);
        chk("mid_rst_valid", 64'(bus.sample_valid), 0);
        chk("mid_rst_busy", 64'(bus.busy), 0);
        chk("mid_rst_overrun", 64'(bus.overrun), 0);
        model_reset();
        reset_n = 1;
        repeat (12) @(negedge clk);
        fill_tbl(0, 32'h7000_0000);
        run_frame(1, 32'h0);

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
